// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared arbiter state encoding and burst counter width
// Ports: none (package). Configuration macro FIFO_ARB_BURST_EN selects burst grants in fifo_rd_arbiter.
package fifo_arb_pkg;
  typedef enum logic [0:0] {ARB = 1'b0, XFER = 1'b1} arb_state_e;
  localparam int BURST_W = 4;
endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: FIFO read-side and output-stage signal bundle
// Signals: port_en/fifo_empty/fifo_rdata/out_ready into the arbiter; fifo_rinc/out_valid/out_data/out_src/busy out of it.
// Modports: master = arbiter side, slave = FIFOs plus consumer side.
interface fifo_rd_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SRC_W      = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0]            port_en;
  logic [NUM_PORTS-1:0]            fifo_empty;
  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_rdata;
  logic [NUM_PORTS-1:0]            fifo_rinc;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [SRC_W-1:0]                out_src;
  logic                            busy;
  modport master (input port_en, fifo_empty, fifo_rdata, out_ready,
                  output fifo_rinc, out_valid, out_data, out_src, busy);
  modport slave  (output port_en, fifo_empty, fifo_rdata, out_ready,
                  input fifo_rinc, out_valid, out_data, out_src, busy);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request after i_ptr wins
// Ports: i_req request vector, i_ptr last granted index, o_valid any request, o_winner granted index.
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int SRC_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SRC_W-1:0]     i_ptr,
  output logic                 o_valid,
  output logic [SRC_W-1:0]     o_winner
);
  logic [SRC_W-1:0] w_idx;
  assign o_valid = |i_req;
  // scan farthest-first so the nearest requester after i_ptr is written last
  always_comb begin
    o_winner = '0;
    w_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_idx = SRC_W'((int'(i_ptr) + k) % NUM_PORTS);
      o_winner = i_req[w_idx] ? w_idx : o_winner;
    end
  end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin pop arbiter sharing one valid/ready consumer across async-FIFO read ports
// Ports: i_rclk read clock; i_rst_n sync active-low reset; bus (master modport) carries port_en, fifo_empty,
//   fifo_rdata, fifo_rinc, out_valid/out_ready/out_data/out_src and busy.
// Macro FIFO_ARB_BURST_EN: hold a grant for up to MAX_BURST pops; undefined gives word-level round-robin.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int SRC_W      = $clog2(NUM_PORTS)
) (
  input logic               i_rclk,
  input logic               i_rst_n,
  fifo_rd_arbiter_if.master bus
);
  if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
    $error("fifo_rd_arbiter: NUM_PORTS or MAX_BURST out of range");
  end
  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_load;
  logic                  w_win_valid;
  logic                  w_pop;
  logic [SRC_W-1:0]      w_winner;
  logic [SRC_W-1:0]      w_sel;
  logic [DATA_WIDTH-1:0] w_word;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic [SRC_W-1:0]      r_src;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  assign w_req  = bus.port_en & ~bus.fifo_empty;
  assign w_load = !r_valid || bus.out_ready;
  assign w_word = bus.fifo_rdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
  rr_pick #(.NUM_PORTS(NUM_PORTS), .SRC_W(SRC_W)) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_win_valid),
    .o_winner(w_winner)
  );
`ifdef FIFO_ARB_BURST_EN
  localparam logic [0:0] ST_ARB  = ARB;
  localparam logic [0:0] ST_XFER = XFER;
  logic [0:0]         r_state;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               w_xfer;
  assign w_xfer   = r_state == ST_XFER;
  assign w_sel    = w_xfer ? r_rr_ptr : w_winner;
  assign w_pop    = w_load && (w_xfer ? w_req[r_rr_ptr] : w_win_valid);
  assign bus.busy = w_xfer || r_valid;
  // a drained or disabled port ends the burst with a one-cycle bubble
  always_ff @(posedge i_rclk) begin
    if (!i_rst_n) begin
      r_state     <= ST_ARB;
      r_burst_cnt <= '0;
    end else if (!w_xfer) begin
      if (w_pop) begin
        r_burst_cnt <= BURST_W'(1);
        r_state     <= (MAX_BURST > 1) ? ST_XFER : ST_ARB;
      end
    end else if (!w_req[r_rr_ptr]) begin
      r_state <= ST_ARB;
    end else if (w_pop) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
      if (r_burst_cnt + 1'b1 == BURST_W'(MAX_BURST)) r_state <= ST_ARB;
    end
  end
`else
  assign w_sel    = w_winner;
  assign w_pop    = w_load && w_win_valid;
  assign bus.busy = r_valid;
`endif
  // pop strobe is gated by reset so a mid-burst reset never consumes a word
  assign bus.fifo_rinc = (w_pop && i_rst_n) ? NUM_PORTS'(1) << w_sel : '0;
  always_ff @(posedge i_rclk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src    <= '0;
      r_rr_ptr <= SRC_W'(NUM_PORTS - 1);
    end else if (w_pop) begin
      r_valid  <= 1'b1;
      r_data   <= w_word;
      r_src    <= w_sel;
      r_rr_ptr <= w_sel;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed self-checking bench for fifo_rd_arbiter with 4 modelled FIFOs
// Ports: none. Head word of FIFO i is 16*i + read index; burst vectors apply when FIFO_ARB_BURST_EN is defined.
module tb_fifo_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic do_fill = 1'b0;
  int fill_n [4];
  int cnt [4];
  int rd_idx [4];
  int pop_empty_err = 0;
  int n_chk = 0;
  int n_pass = 0;
  int seen [4];
  fifo_rd_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(8)) bus ();
  fifo_rd_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .i_rclk (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    assign bus.fifo_empty[g] = cnt[g] == 0;
    assign bus.fifo_rdata[g*8 +: 8] = 8'(16 * g + rd_idx[g]);
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_fill) begin
        cnt[i]    <= fill_n[i];
        rd_idx[i] <= 0;
      end else if (bus.fifo_rinc[i]) begin
        if (cnt[i] == 0) pop_empty_err <= pop_empty_err + 1;
        else begin
          cnt[i]    <= cnt[i] - 1;
          rd_idx[i] <= rd_idx[i] + 1;
        end
      end
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int a, input int b, input int c, input int d);
    fill_n = '{a, b, c, d};
    seen = '{0, 0, 0, 0};
    do_fill = 1'b1;
    tick();
    do_fill = 1'b0;
  endtask
  task automatic run_seq(input string tag, input int exp_src []);
    int got;
    for (int k = 0; k < exp_src.size(); k++) begin
      tick();
      got = bus.out_valid ? int'(bus.out_src) : -1;
      chk($sformatf("%s_src%0d", tag, k), got, exp_src[k]);
      if (exp_src[k] >= 0 && got >= 0) begin
        chk($sformatf("%s_data%0d", tag, k), int'(bus.out_data), 16 * exp_src[k] + seen[exp_src[k]]);
        seen[exp_src[k]]++;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.port_en = 4'hF;
    bus.out_ready = 1'b1;
    fill(8, 8, 8, 8);
    #1;
    chk("rst_rinc", int'(bus.fifo_rinc), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_src", int'(bus.out_src), 0);
    chk("rst_busy", int'(bus.busy), 0);
`ifdef FIFO_ARB_BURST_EN
    bus.port_en = 4'h0;
    rst_n = 1'b1;
    fill(6, 0, 6, 0);
    bus.port_en = 4'hF;
    #1;
    chk("burst_first_rinc", int'(bus.fifo_rinc), 1);
    run_seq("burst", '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, -1, 2, 2, -1});
    chk("burst_idle_rinc", int'(bus.fifo_rinc), 0);
    bus.port_en = 4'h0;
    fill(0, 2, 2, 0);
    bus.port_en = 4'hF;
    run_seq("early", '{1, 1, -1, 2, 2, -1});
`else
    rst_n = 1'b1;
    #1;
    chk("first_grant", int'(bus.fifo_rinc), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_valid%0d", k), int'(bus.out_valid), 1);
      chk($sformatf("rr_src%0d", k), int'(bus.out_src), k % 4);
      chk($sformatf("rr_data%0d", k), int'(bus.out_data), 16 * (k % 4) + k / 4);
    end
    bus.port_en = 4'h0;
    #1;
    chk("mask_all_rinc", int'(bus.fifo_rinc), 0);
    tick();
    chk("drain_valid", int'(bus.out_valid), 0);
    chk("drain_busy", int'(bus.busy), 0);
    bus.port_en = 4'hF;
    bus.out_ready = 1'b0;
    #1;
    chk("bp_first_rinc", int'(bus.fifo_rinc), 1);
    tick();
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_src", int'(bus.out_src), 0);
    chk("bp_data", int'(bus.out_data), 2);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_hold_rinc%0d", k), int'(bus.fifo_rinc), 0);
      tick();
      chk($sformatf("bp_hold_data%0d", k), int'(bus.out_data), 2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rinc", int'(bus.fifo_rinc), 2);
    tick();
    chk("bp_release_src", int'(bus.out_src), 1);
    chk("bp_release_data", int'(bus.out_data), 8'h12);
    bus.port_en = 4'b1011;
    #1;
    chk("mask_rinc", int'(bus.fifo_rinc), 8);
    seen = '{3, 3, 2, 2};
    run_seq("mask", '{3, 0, 1, 3, 0});
    chk("mask_p2_untouched", cnt[2], 6);
    bus.port_en = 4'h0;
    fill(0, 2, 0, 0);
    chk("refill_valid", int'(bus.out_valid), 0);
    bus.port_en = 4'hF;
    #1;
    chk("single_rinc", int'(bus.fifo_rinc), 2);
    run_seq("single", '{1, 1, -1});
    chk("single_idle_rinc", int'(bus.fifo_rinc), 0);
`endif
    bus.port_en = 4'h0;
    fill(8, 8, 8, 8);
    bus.port_en = 4'hF;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rinc", int'(bus.fifo_rinc), 0);
    tick();
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_rinc", int'(bus.fifo_rinc), 1);
    tick();
    chk("rst_release_src", int'(bus.out_src), 0);
    chk("rst_release_data", int'(bus.out_data), 0);
    chk("pop_empty_err", pop_empty_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
